mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the fetch stage (instruction read) and the memory stage (data read/write) of the 5-stage pipeline.
- Sequences each transaction through an address phase and a data phase.
- Returns read data with a one-cycle ready pulse.
- Drives per-side stall requests into the hazard logic.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports (byte strobe width = DATA_W/8)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
inst_req  input  1  fetch request; held high until inst_ready
inst_addr  input  ADDR_W  fetch address; stable while inst_req high
inst_rdata  output  DATA_W  fetch read data; valid when inst_ready
inst_ready  output  1  one-cycle completion pulse for fetch
data_req  input  1  memory-stage request; held high until data_ready
data_wr  input  1  1 = write, 0 = read
data_wstrb  input  DATA_W/8  byte enables for writes
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  write data
data_rdata  output  DATA_W  read data; valid when data_ready
data_ready  output  1  one-cycle completion pulse for data side
mem_req  output  1  address-phase request to memory
mem_wr  output  1  write flag to memory
mem_wstrb  output  DATA_W/8  byte enables (0 for reads)
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_addr_ok  input  1  memory accepted address phase
mem_data_ok  input  1  memory completed data phase
mem_rdata  input  DATA_W  memory read data, valid with mem_data_ok
stall_inst  output  1  fetch must stall (combinational)
stall_data  output  1  memory stage must stall (combinational)

Behaviour:
- FSM states: IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT.
- Reset: while rst is low, state = IDLE, and all registered outputs are 0. This covers inst_ready, data_ready, inst_rdata, data_rdata, mem_req, mem_wr, mem_wstrb, mem_addr and mem_wdata. The grant mask and the round-robin pointer are also cleared.
- IDLE, grant rules:
  - data_req (unmasked) wins over inst_req -> D_ADDR.
  - Else inst_req (unmasked) -> I_ADDR.
  - Else stay in IDLE.
- Grant latches the winning side's address, write flag, strobe and wdata into mem_* registers. Strobe is forced to 0 for reads. mem_req goes high the cycle after the grant.
- x_ADDR: mem_req = 1 with the latched command. On mem_addr_ok, mem_req drops next cycle and the FSM moves to x_WAIT. With no addr_ok, hold indefinitely; the command is unchanged.
- x_WAIT: on mem_data_ok, mem_rdata is captured into that side's rdata register. The side's ready is pulsed high for exactly 1 cycle (the next cycle) and the FSM returns to IDLE.
- rdata registers hold their value until the next completion on the same side.
- Write completion also pulses ready; data_rdata is unchanged on a write.
- mem_addr_ok is ignored outside x_ADDR. mem_data_ok is ignored outside x_WAIT.
- Latency, zero-wait memory (addr_ok and data_ok each on their first eligible cycle): req sampled at cycle T -> mem_req at T+1 -> WAIT at T+2 -> ready at T+3.
- Re-grant mask: in the cycle a side's ready is high, that side's req is ignored by IDLE, because the requester is still holding req for that cycle. The other side may be granted in that same cycle.
- Only one outstanding transaction at any time; there is no pipelining of addr phases.
- Stalls: stall_inst = inst_req & ~inst_ready; stall_data = data_req & ~data_ready.
- A requester dropping req mid-transaction is illegal. The transaction still completes and the ready pulse is still issued.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: when both sides request in IDLE, grant goes to the side not granted most recently. A 1-bit last-grant register is updated on every grant and reset to "inst" (so data wins first).
- Undefined: fixed data-over-inst priority, and no last-grant register exists.

Test Plan:
- Fetch-only read, addr 0x0000_0040, zero-wait memory returning 0x2402_0005 -> mem_req at T+1 with mem_wr=0, mem_wstrb=0; inst_ready pulse at T+3 with inst_rdata=0x2402_0005; stall_inst high T..T+2.
- Data write, addr 0x1000, wdata 0xDEAD_BEEF, wstrb 0xF -> mem_wr=1, mem_wstrb=0xF, mem_wdata=0xDEAD_BEEF; data_ready 1-cycle pulse; data_rdata unchanged.
- Simultaneous inst_req and data_req, macro undefined -> data served first; inst granted in the data_ready cycle; inst_ready exactly 3 cycles after data_ready.
- Both sides requesting continuously, ARB_ROUND_ROBIN_EN defined -> grants alternate D, I, D, I. Same stimulus with the macro undefined -> grants go D, I, D, I only because of the re-grant mask; verify the mask blocks an immediate D re-grant.
- mem_addr_ok delayed 4 cycles, mem_data_ok delayed 3 cycles -> mem_req and mem_addr stay stable for 4 cycles; ready asserts the cycle after data_ok; stall stays high throughout.
- rst driven low during D_WAIT -> all outputs 0 immediately (asynchronous); after release with no reqs, FSM stays IDLE and mem_req stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between instruction fetch
// and the memory stage. Each transaction runs through an address phase
// (mem_req/mem_addr_ok) and then a data phase (mem_data_ok). Completion is a
// one-cycle ready pulse. A side is not re-granted in the cycle its own ready
// is high, because the requester is still holding req during that cycle.
// Optional build macro ARB_ROUND_ROBIN_EN: when both sides request together,
// alternate the grant instead of always preferring the data side.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ready,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ready,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_inst,
  output logic                stall_data
);

  typedef enum logic [2:0] {IDLE, D_ADDR, D_WAIT, I_ADDR, I_WAIT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_grant_d;
  logic                  w_grant_i;
  logic                  w_inst_elig;
  logic                  w_data_elig;
  logic                  r_inst_ready;
  logic                  r_data_ready;
  logic [DATA_W-1:0]     r_inst_rdata;
  logic [DATA_W-1:0]     r_data_rdata;
  logic                  r_mem_req;
  logic                  r_mem_wr;
  logic [DATA_W/8-1:0]   r_mem_wstrb;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  r_last_data;
`endif

  // A side's own ready pulse masks its request for that cycle
  assign w_inst_elig = inst_req & ~r_inst_ready;
  assign w_data_elig = data_req & ~r_data_ready;

  // Next-state and grant decision
  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    unique case (r_state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (w_data_elig && w_inst_elig) begin
          if (r_last_data) w_grant_i = 1'b1;
          else             w_grant_d = 1'b1;
        end else if (w_data_elig) begin
          w_grant_d = 1'b1;
        end else if (w_inst_elig) begin
          w_grant_i = 1'b1;
        end
`else
        if (w_data_elig)      w_grant_d = 1'b1;
        else if (w_inst_elig) w_grant_i = 1'b1;
`endif
        if (w_grant_d)      w_state_nxt = D_ADDR;
        else if (w_grant_i) w_state_nxt = I_ADDR;
      end
      D_ADDR:  if (mem_addr_ok) w_state_nxt = D_WAIT;
      D_WAIT:  if (mem_data_ok) w_state_nxt = IDLE;
      I_ADDR:  if (mem_addr_ok) w_state_nxt = I_WAIT;
      I_WAIT:  if (mem_data_ok) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Memory command, completion pulses and per-side read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_wstrb  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_inst_ready <= (r_state == I_WAIT) && mem_data_ok;
      r_data_ready <= (r_state == D_WAIT) && mem_data_ok;
      if ((r_state == I_WAIT) && mem_data_ok) r_inst_rdata <= mem_rdata;
      // Writes complete without disturbing the last read value
      if ((r_state == D_WAIT) && mem_data_ok && !r_mem_wr) r_data_rdata <= mem_rdata;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_wr    <= data_wr;
        r_mem_wstrb <= data_wr ? data_wstrb : '0;
        r_mem_addr  <= data_addr;
        r_mem_wdata <= data_wdata;
      end else if (w_grant_i) begin
        r_mem_req   <= 1'b1;
        r_mem_wr    <= 1'b0;
        r_mem_wstrb <= '0;
        r_mem_addr  <= inst_addr;
        r_mem_wdata <= '0;
      end else if (((r_state == D_ADDR) || (r_state == I_ADDR)) && mem_addr_ok) begin
        r_mem_req   <= 1'b0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which side won most recently so simultaneous requests alternate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_last_data <= 1'b0;
    else if (w_grant_d) r_last_data <= 1'b1;
    else if (w_grant_i) r_last_data <= 1'b0;
  end
`endif

  assign inst_ready = r_inst_ready;
  assign data_ready = r_data_ready;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  assign mem_req    = r_mem_req;
  assign mem_wr     = r_mem_wr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign stall_inst = inst_req & ~r_inst_ready;
  assign stall_data = data_req & ~r_data_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single-side transactions plus
// hand-written sequences for arbitration, back-to-back traffic and reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        stall_inst;
  logic        stall_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .stall_inst(stall_inst), .stall_data(stall_data)
  );

  int errs = 0;
  int chks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents seen by reads
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2402_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder with programmable address/data phase delays
  int          a_dly = 0;
  int          d_dly = 0;
  int          rsp_cnt = 0;
  bit          rsp_wait = 1'b0;
  logic        cmd_wr_l = 1'b0;
  logic [31:0] cmd_addr_l = '0;
  logic [31:0] grant_log[$];

  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        rsp_wait = 1'b0; rsp_cnt = 0;
      end else if (!rsp_wait && mem_addr_ok) begin
        rsp_wait = 1'b1; rsp_cnt = 0;
      end else if (rsp_wait && mem_data_ok) begin
        rsp_wait = 1'b0; rsp_cnt = 0;
      end
      #1;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (!rst) begin
        rsp_wait = 1'b0; rsp_cnt = 0;
      end else if (!rsp_wait) begin
        if (mem_req) begin
          if (rsp_cnt >= a_dly) begin
            mem_addr_ok = 1'b1;
            cmd_wr_l    = mem_wr;
            cmd_addr_l  = mem_addr;
            grant_log.push_back(mem_addr);
          end else rsp_cnt++;
        end
      end else begin
        if (rsp_cnt >= d_dly) begin
          mem_data_ok = 1'b1;
          mem_rdata   = cmd_wr_l ? 32'hBAD0_0BAD : mem_model(cmd_addr_l);
        end else rsp_cnt++;
      end
    end
  end

  // Scoreboard: expected read data per side, consumed on each ready pulse
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] model_drd = '0;

  task automatic push_exp(input bit side_d, input bit wr, input logic [31:0] addr);
    if (!side_d) exp_i_q.push_back(mem_model(addr));
    else if (wr) exp_d_q.push_back(model_drd);
    else begin
      model_drd = mem_model(addr);
      exp_d_q.push_back(model_drd);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (inst_ready) begin
        if (exp_i_q.size() == 0) begin
          chks++; errs++;
          $display("FAIL sb_inst: got unexpected inst_ready, required none");
        end else check("sb_inst_rdata", inst_rdata, exp_i_q.pop_front());
      end
      if (data_ready) begin
        if (exp_d_q.size() == 0) begin
          chks++; errs++;
          $display("FAIL sb_data: got unexpected data_ready, required none");
        end else check("sb_data_rdata", data_rdata, exp_d_q.pop_front());
      end
    end
  end

  typedef struct {
    bit          side_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ad;
    int          dd;
    logic [3:0]  exp_strb;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // One single-side transaction; called at posedge+1
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit seen;
    logic rdy, stl;
    a_dly = v.ad; d_dly = v.dd;
    if (v.side_d) begin
      data_req = 1'b1; data_wr = v.wr; data_addr = v.addr;
      data_wdata = v.wdata; data_wstrb = v.wstrb;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    push_exp(v.side_d, v.wr, v.addr);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      rdy = v.side_d ? data_ready : inst_ready;
      stl = v.side_d ? stall_data : stall_inst;
      if (cyc == 0) check($sformatf("v%0d_req_idle", idx), mem_req, 1'b0);
      if (cyc >= 1 && cyc <= 1 + v.ad) begin
        check($sformatf("v%0d_req_c%0d", idx, cyc), mem_req, 1'b1);
        check($sformatf("v%0d_addr_c%0d", idx, cyc), mem_addr, v.addr);
      end
      if (cyc == 1) begin
        check($sformatf("v%0d_wr", idx), mem_wr, v.wr);
        check($sformatf("v%0d_wstrb", idx), mem_wstrb, v.exp_strb);
        if (v.wr) check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
      end
      if (cyc >= 2 + v.ad && !rdy)
        check($sformatf("v%0d_req_low_c%0d", idx, cyc), mem_req, 1'b0);
      if (rdy) begin
        seen = 1'b1;
        check($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        check($sformatf("v%0d_stall_done", idx), stl, 1'b0);
      end else begin
        check($sformatf("v%0d_stall_c%0d", idx, cyc), stl, 1'b1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!seen) begin
      chks++; errs++;
      $display("FAIL v%0d_timeout: got no ready in 40 cycles, required ready", idx);
    end
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_pulse_width", idx), v.side_d ? data_ready : inst_ready, 1'b0);
    @(posedge clk); #1;
  endtask

  // Both sides request in the same cycle; returns the ready cycle of each
  task automatic run_pair(input logic [31:0] ia, input logic [31:0] da, output int dc, output int ic);
    a_dly = 0; d_dly = 0;
    grant_log.delete();
    inst_req = 1'b1; inst_addr = ia;
    data_req = 1'b1; data_wr = 1'b0; data_addr = da; data_wstrb = 4'hF;
    push_exp(1'b0, 1'b0, ia);
    push_exp(1'b1, 1'b0, da);
    dc = -1; ic = -1;
    for (int c = 0; c < 30 && (dc < 0 || ic < 0); c++) begin
      @(negedge clk);
      if (data_ready) dc = c;
      if (inst_ready) ic = c;
      @(posedge clk); #1;
      if (dc >= 0) data_req = 1'b0;
      if (ic >= 0) inst_req = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Wait for one side's ready, bounded
  task automatic wait_ready(input bit side_d, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(side_d ? data_ready : inst_ready) && n < 40);
    if (n >= 40) begin
      chks++; errs++;
      $display("FAIL %s: got no ready in 40 cycles, required ready", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int dc, ic;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 4'h0, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 0, 4'h0, 3};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 4'hF, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         4'h0, 4, 3, 4'h0, 10};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_2004, 32'h5555_AAAA, 4'hF, 1, 2, 4'h0, 6};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3, 2, 0, 4'h3, 5};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 1, 4'h0, 4};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_inst_ready", inst_ready, 1'b0);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_data_rdata", data_rdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Simultaneous requests from idle: data first, inst granted in data_ready cycle
    run_pair(32'h0000_0100, 32'h0000_2000, dc, ic);
    check("pair_data_cycle", dc, 3);
    check("pair_inst_cycle", ic, 6);
    check("pair_grant_n", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("pair_grant0", grant_log[0], 32'h0000_2000);
      check("pair_grant1", grant_log[1], 32'h0000_0100);
    end

    // Continuous requests on both sides: grants alternate D, I, D, I, D, I
    a_dly = 0; d_dly = 0;
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h3000 + 32'(k * 4);
          push_exp(1'b1, 1'b0, data_addr);
          wait_ready(1'b1, "cont_data_timeout");
        end
        data_req = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          inst_req = 1'b1; inst_addr = 32'h0200 + 32'(k * 4);
          push_exp(1'b0, 1'b0, inst_addr);
          wait_ready(1'b0, "cont_inst_timeout");
        end
        inst_req = 1'b0;
      end
    join
    @(posedge clk); #1;
    check("cont_grant_n", grant_log.size(), 6);
    for (int j = 0; j < 6 && j < grant_log.size(); j++)
      check($sformatf("cont_grant%0d", j), grant_log[j],
            (j % 2 == 0) ? 32'h3000 + 32'((j / 2) * 4) : 32'h0200 + 32'((j / 2) * 4));

    // Tie after a data-only transaction: round robin picks inst, fixed picks data
    run_vec(vecs[1], 7);
    run_pair(32'h0000_0300, 32'h0000_4000, dc, ic);
`ifdef ARB_ROUND_ROBIN_EN
    check("tie_first_grant", grant_log.size() > 0 ? grant_log[0] : 32'hFFFF_FFFF, 32'h0000_0300);
    check("tie_inst_cycle", ic, 3);
    check("tie_data_cycle", dc, 6);
`else
    check("tie_first_grant", grant_log.size() > 0 ? grant_log[0] : 32'hFFFF_FFFF, 32'h0000_4000);
    check("tie_data_cycle", dc, 3);
    check("tie_inst_cycle", ic, 6);
`endif

    // Asynchronous reset while a data read waits in D_WAIT
    a_dly = 0; d_dly = 20;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_5550;
    push_exp(1'b1, 1'b0, data_addr);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 1'b0);
    check("arst_mem_wr", mem_wr, 1'b0);
    check("arst_mem_wstrb", mem_wstrb, 4'h0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_wdata", mem_wdata, 32'h0);
    check("arst_inst_rdata", inst_rdata, 32'h0);
    check("arst_data_rdata", data_rdata, 32'h0);
    check("arst_inst_ready", inst_ready, 1'b0);
    check("arst_data_ready", data_ready, 1'b0);
    data_req = 1'b0;
    exp_i_q.delete(); exp_d_q.delete();
    model_drd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_req_c%0d", c), mem_req, 1'b0);
      check($sformatf("post_rst_dready_c%0d", c), data_ready, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
